// File: rtl/ysyx_22041071_lsu_pkg.sv
// Shared definitions for the load/store unit:
// opcodes, funct3 encodings, FSM states, alignment helper.
package ysyx_22041071_lsu_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   // size is funct3[1:0]: 0=byte 1=half 2=word 3=double
   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [2:0] off);
      logic m;
      m = 1'b0;
      case (size)
         2'd0:    m = 1'b0;
         2'd1:    m = off[0];
         2'd2:    m = |off[1:0];
         default: m = |off;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ysyx_22041071_lsu_align.sv
// Lane alignment: load lane extract + extend,
// store data shift + byte strobes.
module ysyx_22041071_lsu_align
   import ysyx_22041071_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]        funct3,
   input  logic [2:0]        off,
   input  logic [XLEN-1:0]   st_data,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN/8-1:0] wstrb,
   output logic [XLEN-1:0]   ld_data
);

   localparam int STRB_W = XLEN / 8;

   logic [5:0]      bits;
   logic [XLEN-1:0] shifted;
   logic [63:0]     sh64;
   logic [63:0]     ext64;
   logic [63:0]     mask64;
   logic [63:0]     st64;
   logic [7:0]      bmask;

   assign bits = {off, 3'b000};

   always_comb begin
      shifted = rdata >> bits;
      sh64    = 64'(shifted);
      ext64   = '0;
      case (funct3)
         F3_B:    ext64 = {{56{sh64[7]}}, sh64[7:0]};
         F3_H:    ext64 = {{48{sh64[15]}}, sh64[15:0]};
         F3_W:    ext64 = {{32{sh64[31]}}, sh64[31:0]};
         F3_BU:   ext64 = {56'd0, sh64[7:0]};
         F3_HU:   ext64 = {48'd0, sh64[15:0]};
         F3_WU:   ext64 = {32'd0, sh64[31:0]};
         default: ext64 = sh64;
      endcase
      ld_data = ext64[XLEN-1:0];
   end

   // Bytes shifted past the top lane are simply lost.
   always_comb begin
      bmask  = 8'h00;
      mask64 = '0;
      case (funct3[1:0])
         2'd0:    bmask = 8'h01;
         2'd1:    bmask = 8'h03;
         2'd2:    bmask = 8'h0F;
         default: bmask = 8'hFF;
      endcase
      for (int i = 0; i < 8; i++) begin
         mask64[i*8 +: 8] = {8{bmask[i]}};
      end
      st64  = 64'(st_data) & mask64;
      wdata = XLEN'(st64) << bits;
      wstrb = STRB_W'(bmask << off);
   end

endmodule

// File: rtl/ysyx_22041071_lsu.sv
// Load/store unit: IDLE/REQ/WAIT/DONE sequencer.
// Define YSYX_22041071_MISALIGN_TRAP_EN to trap misaligned accesses.
module ysyx_22041071_lsu
   import ysyx_22041071_lsu_pkg::*;
#(
   parameter int          XLEN     = 64,
   parameter int          ADDR_W   = 64,
   parameter logic [63:0] MEM_BASE = 64'h8000_0000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [31:0]       in_ins,
   input  logic              in_reg_w_en,
   input  logic [4:0]        in_rdest,
   input  logic [XLEN-1:0]   in_alu_result,
   input  logic [XLEN-1:0]   in_rt_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [31:0]       out_ins,
   output logic              out_reg_w_en,
   output logic [4:0]        out_rdest,
   output logic [XLEN-1:0]   out_wb_data,
   output logic              out_excp,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_wen,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [XLEN/8-1:0] mem_req_wstrb,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_resp_rdata
);

   localparam int OFFW = $clog2(XLEN / 8);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(MEM_BASE);

   lsu_state_e state, state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   rt_q;
   logic [XLEN-1:0]   ld_data;
   logic [2:0]        in_f3;
   logic              in_load, in_store, in_mem;
   logic              in_illegal, in_misal, in_trap;
   logic              acc, resp_take;

   assign in_f3    = in_ins[14:12];
   assign in_load  = in_ins[6:0] == OP_LOAD;
   assign in_store = in_ins[6:0] == OP_STORE;
   assign in_mem   = in_load || in_store;

   // 64-bit accesses do not exist on a 32-bit datapath.
   assign in_illegal = (XLEN == 32) &&
      ((in_load && (in_f3 == F3_D || in_f3 == F3_WU)) ||
       (in_store && in_f3 == F3_D));

`ifdef YSYX_22041071_MISALIGN_TRAP_EN
   logic [2:0] in_off;
   assign in_off   = 3'(in_alu_result[OFFW-1:0]);
   assign in_misal = in_mem && misaligned(in_f3[1:0], in_off);
`else
   assign in_misal = 1'b0;
`endif

   assign in_trap = in_illegal || in_misal;

   assign in_ready      = state == S_IDLE;
   assign out_valid     = state == S_DONE;
   assign mem_req_valid = state == S_REQ;
   assign acc           = in_valid && in_ready;
   assign resp_take     = (state == S_WAIT) && mem_resp_valid;

   assign mem_req_wen  = out_ins[6:0] == OP_STORE;
   assign mem_req_addr = (addr_q - BASE) >> OFFW;

   ysyx_22041071_lsu_align #(.XLEN(XLEN)) u_align (
      .funct3  (out_ins[14:12]),
      .off     (3'(addr_q[OFFW-1:0])),
      .st_data (rt_q),
      .rdata   (mem_resp_rdata),
      .wdata   (mem_req_wdata),
      .wstrb   (mem_req_wstrb),
      .ld_data (ld_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (acc) begin
               state_nxt = (in_mem && !in_trap) ? S_REQ : S_DONE;
            end
         end
         S_REQ:  if (mem_req_ready)  state_nxt = S_WAIT;
         S_WAIT: if (mem_resp_valid) state_nxt = S_DONE;
         S_DONE: if (out_ready)      state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_pc       <= '0;
         out_ins      <= '0;
         out_reg_w_en <= 1'b0;
         out_rdest    <= '0;
         out_wb_data  <= '0;
         out_excp     <= 1'b0;
         addr_q       <= '0;
         rt_q         <= '0;
      end else if (acc) begin
         out_pc       <= in_pc;
         out_ins      <= in_ins;
         out_reg_w_en <= in_reg_w_en && !in_trap;
         out_rdest    <= in_rdest;
         out_wb_data  <= in_alu_result;
         out_excp     <= in_trap;
         addr_q       <= ADDR_W'(in_alu_result);
         rt_q         <= in_rt_data;
      end else if (resp_take && !mem_req_wen) begin
         out_wb_data  <= ld_data;
      end
   end

endmodule

// File: tb/tb_ysyx_22041071_lsu.sv
// Self-checking bench for ysyx_22041071_lsu (XLEN=64).
// Scoreboard queues hold expected requests and results.
module tb_ysyx_22041071_lsu;

   typedef struct packed {
      logic        wen;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
   } req_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ins;
      logic        wen;
      logic [4:0]  rd;
      logic [63:0] wb;
      logic        excp;
   } out_t;

   typedef struct packed {
      logic        st;
      logic [2:0]  f3;
      logic [7:0]  off;
      logic [63:0] exp;
      logic [7:0]  strb;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [31:0] in_ins;
   logic        in_reg_w_en;
   logic [4:0]  in_rdest;
   logic [63:0] in_alu_result;
   logic [63:0] in_rt_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_ins;
   logic        out_reg_w_en;
   logic [4:0]  out_rdest;
   logic [63:0] out_wb_data;
   logic        out_excp;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_wen;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;

   int   checks = 0;
   int   errors = 0;
   req_t exp_req[$];
   out_t exp_out[$];

   localparam logic [63:0] BASE = 64'h8000_0000;

   always #5 clk = ~clk;

   ysyx_22041071_lsu dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_ins         (in_ins),
      .in_reg_w_en    (in_reg_w_en),
      .in_rdest       (in_rdest),
      .in_alu_result  (in_alu_result),
      .in_rt_data     (in_rt_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_ins        (out_ins),
      .out_reg_w_en   (out_reg_w_en),
      .out_rdest      (out_rdest),
      .out_wb_data    (out_wb_data),
      .out_excp       (out_excp),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_wen    (mem_req_wen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wstrb  (mem_req_wstrb),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   function automatic logic [31:0] ld_ins(input logic [2:0] f3);
      return {12'h000, 5'd1, f3, 5'd10, 7'b0000011};
   endfunction

   function automatic logic [31:0] st_ins(input logic [2:0] f3);
      return {7'h00, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
   endfunction

   localparam logic [31:0] ADD_INS = 32'h0020_8533;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one instruction through and captures what the DUT shows.
   task automatic run_txn(
      input  logic [63:0] pc,
      input  logic [31:0] ins,
      input  logic        wen,
      input  logic [4:0]  rd,
      input  logic [63:0] alu,
      input  logic [63:0] rt,
      input  logic [63:0] rdata,
      input  int          req_stall,
      input  int          out_stall,
      output req_t        r,
      output out_t        o,
      output bit          saw_req,
      output bit          got_out,
      output bit          stable,
      output int          lat
   );
      int n;
      saw_req = 0;
      got_out = 0;
      stable  = 1;
      lat     = 0;
      r       = '0;
      o       = '0;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      in_valid      = 1'b1;
      in_pc         = pc;
      in_ins        = ins;
      in_reg_w_en   = wen;
      in_rdest      = rd;
      in_alu_result = alu;
      in_rt_data    = rt;
      tick();
      in_valid = 1'b0;
      lat      = 1;
      n        = 0;
      while (!out_valid && n < 50) begin
         if (mem_req_valid && !saw_req) begin
            saw_req = 1;
            r.wen   = mem_req_wen;
            r.addr  = mem_req_addr;
            r.wdata = mem_req_wdata;
            r.strb  = mem_req_wstrb;
            repeat (req_stall) begin
               tick();
               lat++;
               if (mem_req_valid !== 1'b1 || in_ready !== 1'b0 ||
                   mem_req_wen !== r.wen || mem_req_addr !== r.addr ||
                   mem_req_wdata !== r.wdata || mem_req_wstrb !== r.strb)
                  stable = 0;
            end
            mem_req_ready = 1'b1;
            tick();
            lat++;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rdata;
            tick();
            lat++;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
         end else begin
            if (in_ready !== 1'b0) stable = 0;
            tick();
            lat++;
         end
         n++;
      end
      if (out_valid) begin
         got_out = 1;
         o.pc    = out_pc;
         o.ins   = out_ins;
         o.wen   = out_reg_w_en;
         o.rd    = out_rdest;
         o.wb    = out_wb_data;
         o.excp  = out_excp;
         repeat (out_stall) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_pc !== o.pc || out_ins !== o.ins ||
                out_reg_w_en !== o.wen || out_rdest !== o.rd ||
                out_wb_data !== o.wb || out_excp !== o.excp)
               stable = 0;
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_in_ready got %b want 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valids got %b%b want 00",
                  out_valid, mem_req_valid);
      end
      checks++;
      if (out_excp !== 1'b0 || out_reg_w_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_flags got %b%b want 00",
                  out_excp, out_reg_w_en);
      end
      checks++;
      if (out_ins !== 32'd0 || out_rdest !== 5'd0 ||
          out_wb_data !== 64'd0) begin
         errors++;
         $display("FAIL rst_data got %h %h %h want 0",
                  out_ins, out_rdest, out_wb_data);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_lb();
      req_t r, er;
      out_t o, eo;
      bit   s, g, st;
      int   l;
      exp_req.push_back('{wen: 1'b0, addr: 64'd0,
                          wdata: 64'd0, strb: 8'd0});
      exp_out.push_back('{pc: 64'h100, ins: ld_ins(3'b000),
                          wen: 1'b1, rd: 5'd10,
                          wb: 64'hFFFF_FFFF_FFFF_FFF0, excp: 1'b0});
      run_txn(64'h100, ld_ins(3'b000), 1'b1, 5'd10,
              BASE + 64'd3, 64'd0, 64'h0000_0000_F000_0000,
              0, 0, r, o, s, g, st, l);
      er = exp_req.pop_front();
      eo = exp_out.pop_front();
      checks++;
      if (!s || r.wen !== er.wen || r.addr !== er.addr) begin
         errors++;
         $display("FAIL lb_req got %b %b %h want 1 %b %h",
                  s, r.wen, r.addr, er.wen, er.addr);
      end
      checks++;
      if (!g || o.wb !== eo.wb) begin
         errors++;
         $display("FAIL lb_wb got %b %h want %h", g, o.wb, eo.wb);
      end
      checks++;
      if (o.pc !== eo.pc || o.ins !== eo.ins || o.rd !== eo.rd ||
          o.wen !== eo.wen || o.excp !== eo.excp) begin
         errors++;
         $display("FAIL lb_fields got %h %h %h %b %b", o.pc, o.ins,
                  o.rd, o.wen, o.excp);
      end
   endtask

   task automatic test_sh();
      req_t r, er;
      out_t o;
      bit   s, g, st;
      int   l;
      exp_req.push_back('{wen: 1'b1, addr: 64'd0,
                          wdata: 64'h1234_0000_0000_0000,
                          strb: 8'hC0});
      run_txn(64'h104, st_ins(3'b001), 1'b0, 5'd0,
              BASE + 64'd6, 64'h1234, 64'd0,
              0, 0, r, o, s, g, st, l);
      er = exp_req.pop_front();
      checks++;
      if (!s || r !== er) begin
         errors++;
         $display("FAIL sh_req got %b %h %h %h want %h %h %h",
                  r.wen, r.addr, r.wdata, r.strb,
                  er.addr, er.wdata, er.strb);
      end
      checks++;
      if (!g || o.excp !== 1'b0) begin
         errors++;
         $display("FAIL sh_done got %b excp %b want 1 0", g, o.excp);
      end
   endtask

   task automatic test_alu();
      req_t r;
      out_t o, eo;
      bit   s, g, st;
      int   l;
      exp_out.push_back('{pc: 64'h108, ins: ADD_INS, wen: 1'b1,
                          rd: 5'd10, wb: 64'h55, excp: 1'b0});
      run_txn(64'h108, ADD_INS, 1'b1, 5'd10, 64'h55, 64'd0, 64'd0,
              0, 0, r, o, s, g, st, l);
      eo = exp_out.pop_front();
      checks++;
      if (!g || l != 1) begin
         errors++;
         $display("FAIL alu_latency got %0d want 1", l);
      end
      checks++;
      if (o !== eo) begin
         errors++;
         $display("FAIL alu_out got wb %h wen %b want wb %h wen %b",
                  o.wb, o.wen, eo.wb, eo.wen);
      end
      checks++;
      if (s) begin
         errors++;
         $display("FAIL alu_noreq got req 1 want 0");
      end
   endtask

   task automatic test_lanes();
      vec_t v[10];
      req_t r, er;
      out_t o, eo;
      bit   s, g, st;
      int   l;
      v = '{
         '{1'b0, 3'b100, 8'h11, 64'h0000_0000_0000_00EE, 8'h00},
         '{1'b0, 3'b001, 8'h06, 64'hFFFF_FFFF_FFFF_8899, 8'h00},
         '{1'b0, 3'b101, 8'h06, 64'h0000_0000_0000_8899, 8'h00},
         '{1'b0, 3'b010, 8'h04, 64'hFFFF_FFFF_8899_AABB, 8'h00},
         '{1'b0, 3'b110, 8'h04, 64'h0000_0000_8899_AABB, 8'h00},
         '{1'b0, 3'b011, 8'h18, 64'h8899_AABB_CCDD_EEFF, 8'h00},
         '{1'b0, 3'b000, 8'h02, 64'hFFFF_FFFF_FFFF_FFDD, 8'h00},
         '{1'b1, 3'b000, 8'h25, 64'h0000_0800_0000_0000, 8'h20},
         '{1'b1, 3'b010, 8'h04, 64'h0506_0708_0000_0000, 8'hF0},
         '{1'b1, 3'b011, 8'h08, 64'h0102_0304_0506_0708, 8'hFF}
      };
      for (int i = 0; i < 10; i++) begin
         exp_req.push_back('{wen: v[i].st,
                             addr: 64'(v[i].off >> 3),
                             wdata: v[i].exp, strb: v[i].strb});
         exp_out.push_back('{pc: 64'h200 + 64'(i * 4),
                             ins: v[i].st ? st_ins(v[i].f3)
                                          : ld_ins(v[i].f3),
                             wen: !v[i].st, rd: 5'd10,
                             wb: v[i].exp, excp: 1'b0});
         run_txn(64'h200 + 64'(i * 4),
                 v[i].st ? st_ins(v[i].f3) : ld_ins(v[i].f3),
                 !v[i].st, 5'd10, BASE + 64'(v[i].off),
                 64'h0102_0304_0506_0708, 64'h8899_AABB_CCDD_EEFF,
                 i % 2, 0, r, o, s, g, st, l);
         er = exp_req.pop_front();
         eo = exp_out.pop_front();
         checks++;
         if (!s || r.wen !== er.wen || r.addr !== er.addr) begin
            errors++;
            $display("FAIL lane%0d_req got %b %b %h want %b %h",
                     i, s, r.wen, r.addr, er.wen, er.addr);
         end
         checks++;
         if (v[i].st &&
             (r.wdata !== er.wdata || r.strb !== er.strb)) begin
            errors++;
            $display("FAIL lane%0d_store got %h %h want %h %h",
                     i, r.wdata, r.strb, er.wdata, er.strb);
         end else if (!v[i].st && (!g || o.wb !== eo.wb)) begin
            errors++;
            $display("FAIL lane%0d_load got %h want %h",
                     i, o.wb, eo.wb);
         end
         checks++;
         if (!g || o.wen !== eo.wen || o.excp !== 1'b0 ||
             o.pc !== eo.pc) begin
            errors++;
            $display("FAIL lane%0d_out got %b %b %h want %b 0 %h",
                     i, o.wen, o.excp, o.pc, eo.wen, eo.pc);
         end
      end
   endtask

   task automatic test_stall();
      req_t r;
      out_t o;
      bit   s, g, st;
      int   l;
      exp_out.push_back('{pc: 64'h300, ins: ld_ins(3'b010),
                          wen: 1'b1, rd: 5'd10,
                          wb: 64'hFFFF_FFFF_CAFE_F00D, excp: 1'b0});
      run_txn(64'h300, ld_ins(3'b010), 1'b1, 5'd10, BASE + 64'h40,
              64'd0, 64'h1111_1111_CAFE_F00D,
              4, 3, r, o, s, g, st, l);
      checks++;
      if (!s || r.addr !== 64'd8) begin
         errors++;
         $display("FAIL stall_req got %b %h want 1 8", s, r.addr);
      end
      checks++;
      if (!st) begin
         errors++;
         $display("FAIL stall_hold got unstable want stable");
      end
      checks++;
      if (!g || o !== exp_out[0]) begin
         errors++;
         $display("FAIL stall_out got %h want %h",
                  o.wb, exp_out[0].wb);
      end
      void'(exp_out.pop_front());
   endtask

   task automatic test_misalign();
      req_t r;
      out_t o;
      bit   s, g, st;
      int   l;
      run_txn(64'h400, ld_ins(3'b010), 1'b1, 5'd10, BASE + 64'd2,
              64'd0, 64'h0000_1111_2222_3333,
              0, 0, r, o, s, g, st, l);
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
      checks++;
      if (s || !g || o.excp !== 1'b1 || o.wen !== 1'b0) begin
         errors++;
         $display("FAIL mis_lw got req %b excp %b wen %b want 0 1 0",
                  s, o.excp, o.wen);
      end
`else
      checks++;
      if (!s || r.addr !== 64'd0 || !g || o.excp !== 1'b0 ||
          o.wb !== 64'h0000_0000_1111_2222) begin
         errors++;
         $display("FAIL mis_lw got %b %h %b %h want 1 0 0 11112222",
                  s, r.addr, o.excp, o.wb);
      end
`endif
      run_txn(64'h404, st_ins(3'b010), 1'b0, 5'd0, BASE + 64'd6,
              64'hAABB_CCDD, 64'd0, 0, 0, r, o, s, g, st, l);
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
      checks++;
      if (s || !g || o.excp !== 1'b1) begin
         errors++;
         $display("FAIL mis_sw got req %b excp %b want 0 1",
                  s, o.excp);
      end
`else
      checks++;
      if (!s || r.strb !== 8'hC0 ||
          r.wdata !== 64'hCCDD_0000_0000_0000 || o.excp !== 1'b0) begin
         errors++;
         $display("FAIL mis_sw got %h %h %b want c0 ccdd000000000000 0",
                  r.strb, r.wdata, o.excp);
      end
`endif
   endtask

   task automatic test_resp_ignored();
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      mem_resp_valid = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
          mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_resp got %b%b%b want 100",
                  in_ready, out_valid, mem_req_valid);
      end
   endtask

   task automatic test_reset_mid();
      int  n;
      bit  bad;
      n = 0;
      in_valid      = 1'b1;
      in_pc         = 64'h500;
      in_ins        = ld_ins(3'b011);
      in_reg_w_en   = 1'b1;
      in_rdest      = 5'd10;
      in_alu_result = BASE;
      tick();
      in_valid = 1'b0;
      while (!mem_req_valid && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!mem_req_valid) begin
         errors++;
         $display("FAIL rmid_req got 0 want 1");
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async got %b%b want 10",
                  in_ready, out_valid);
      end
      tick();
      reset_n        = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'h1234;
      tick();
      mem_resp_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
         tick();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL rmid_after got out_valid/in_ready wrong want 0/1");
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      in_valid       = 1'b0;
      in_pc          = '0;
      in_ins         = '0;
      in_reg_w_en    = 1'b0;
      in_rdest       = '0;
      in_alu_result  = '0;
      in_rt_data     = '0;
      out_ready      = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      test_reset();
      test_lb();
      test_sh();
      test_alu();
      test_lanes();
      test_stall();
      test_misalign();
      test_resp_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
